pc_next: RTL and testbench

PC_NEXT -- requirements
Module: pc_next

---
 rtl/pc_next_pkg.sv | 10 +
 rtl/pc_target.sv | 20 ++
 rtl/pc_next.sv | 87 ++++++++
 tb/tb_pc_next.sv | 131 +++++++++++++
 4 files changed

// File: rtl/pc_next_pkg.sv
// Shared types and constants for the fetch-address generator.
package pc_next_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;
endpackage

// File: rtl/pc_target.sv
// Combinational redirect target: jump outranks branch when both are raised.
module pc_target
  import pc_next_pkg::*;
(
  input  logic [PC_W-1:0] pc_plus4_i,
  input  logic [PC_W-1:0] shift_i,
  input  logic [25:0]     jidx_i,
  input  logic            branch_i,
  input  logic            jump_i,
  output logic [PC_W-1:0] tgt_o,
  output logic            tgt_vld_o
);
  logic [PC_W-1:0] jtgt, btgt;

  assign jtgt      = {pc_plus4_i[PC_W-1:PC_W-4], jidx_i, 2'b00};
  // Low offset bits are dropped so a misaligned offset cannot misalign the pc.
  assign btgt      = pc_plus4_i + (shift_i & ~32'h3);
  assign tgt_o     = jump_i ? jtgt : btgt;
  assign tgt_vld_o = jump_i | branch_i;
endmodule

// File: rtl/pc_next.sv
// Program counter with boot/fetch/hold control and a one-deep redirect buffer.
module pc_next
  import pc_next_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] shift_in,
  input  logic            branch,
  input  logic            jump,
  input  logic [25:0]     jump_index,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            redirect_pending
);
  localparam logic [PC_W-1:0] RV = {RESET_VECTOR[PC_W-1:2], 2'b00};

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [PC_W-1:0] live_tgt;
  logic            live_vld;
  logic            accept;

  assign pc_plus4 = pc_q + 32'd4;

  pc_target u_tgt (
    .pc_plus4_i (pc_plus4),
    .shift_i    (shift_in),
    .jidx_i     (jump_index),
    .branch_i   (branch),
    .jump_i     (jump),
    .tgt_o      (live_tgt),
    .tgt_vld_o  (live_vld)
  );

  assign accept = (state_q == ST_FETCH) && imem_ready && !stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = stall ? ST_HOLD : ST_FETCH;
      ST_HOLD:  state_d = stall ? ST_HOLD : ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (accept) begin
      if (live_vld)        pc_d = live_tgt;
      else if (pend_vld_q) pc_d = pend_q;
      else                 pc_d = pc_plus4;
      pend_vld_d = 1'b0;
    end else if (live_vld) begin
      // Redirect seen while fetch is not moving: keep the newest target.
      pend_d     = live_tgt;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= {pc_d[PC_W-1:2], 2'b00};
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign pc               = pc_q;
  assign pc_valid         = (state_q == ST_FETCH);
  assign redirect_pending = pend_vld_q;
endmodule

// File: tb/tb_pc_next.sv
// Directed scoreboard bench for pc_next: driver queues expected post-edge state, monitor compares.
module tb_pc_next;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] shift_in = '0;
  logic        branch = 1'b0, jump = 1'b0, stall = 1'b0, imem_ready = 1'b0;
  logic [25:0] jump_index = '0;
  logic [31:0] pc, pc_plus4;
  logic        pc_valid, redirect_pending;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        rp;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_cmp = 0, n_err = 0, n_id = 0;
  event mon_kick;

  pc_next dut (
    .clk(clk), .rst_n(rst_n), .shift_in(shift_in), .branch(branch), .jump(jump),
    .jump_index(jump_index), .stall(stall), .imem_ready(imem_ready),
    .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid), .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] epc, input logic ev, input logic erp);
    exp_t x;
    x.pc = epc; x.v = ev; x.rp = erp; x.id = n_id;
    n_id++;
    sb_q.push_back(x);
  endtask

  // Drive inputs for the coming rising edge and queue the state expected after it.
  task automatic step(input logic r, input logic b, input logic j, input logic [31:0] sh,
                      input logic [25:0] ji, input logic st, input logic rdy,
                      input logic [31:0] epc, input logic ev, input logic erp);
    @(negedge clk);
    rst_n = r; branch = b; jump = j; shift_in = sh; jump_index = ji;
    stall = st; imem_ready = rdy;
    push(epc, ev, erp);
  endtask

  initial begin
    forever begin
      @(posedge clk or mon_kick);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || pc_plus4 !== e.pc + 32'd4 || pc_valid !== e.v ||
            redirect_pending !== e.rp) begin
          n_err++;
          $display("FAIL chk%0d: got pc=%h p4=%h v=%b rp=%b, want pc=%h p4=%h v=%b rp=%b",
                   e.id, pc, pc_plus4, pc_valid, redirect_pending,
                   e.pc, e.pc + 32'd4, e.v, e.rp);
        end
      end
    end
  end

  initial begin
    // reset holds BOOT at the reset vector
    step(0,0,0,32'h0,26'h0,0,1, 32'h0,0,0);
    step(0,0,0,32'h0,26'h0,0,1, 32'h0,0,0);
    // release: BOOT -> FETCH, then sequential fetch
    step(1,0,0,32'h0,26'h0,0,1, 32'h0,1,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h4,1,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h8,1,0);
    // jump to 0x100, branches forward/backward, misaligned offset bits ignored
    step(1,0,1,32'h0,26'h40,0,1, 32'h100,1,0);
    step(1,1,0,32'h20,26'h0,0,1, 32'h124,1,0);
    step(1,0,1,32'h0,26'h40,0,1, 32'h100,1,0);
    step(1,1,0,32'hFFFF_FFF8,26'h0,0,1, 32'hFC,1,0);
    step(1,1,0,32'h23,26'h0,0,1, 32'h120,1,0);
    // reach 0x3000_0010, then jump beats simultaneous branch
    step(1,1,0,32'h2FFF_FEEC,26'h0,0,1, 32'h3000_0010,1,0);
    step(1,1,1,32'h20,26'h40,0,1, 32'h3000_0100,1,0);
    // reach 0x200; branch while memory busy is held pending
    step(1,1,0,32'hD000_00FC,26'h0,0,1, 32'h200,1,0);
    step(1,1,0,32'h40,26'h0,0,0, 32'h200,1,1);
    step(1,0,0,32'h0,26'h0,0,0, 32'h200,1,1);
    step(1,0,0,32'h0,26'h0,0,1, 32'h244,1,0);
    // newer pending redirect overwrites older one
    step(1,1,0,32'h10,26'h0,0,0, 32'h244,1,1);
    step(1,0,1,32'h0,26'h100,0,0, 32'h244,1,1);
    step(1,0,0,32'h0,26'h0,0,1, 32'h400,1,0);
    // live redirect beats pending one on accept
    step(1,1,0,32'h8,26'h0,0,0, 32'h400,1,1);
    step(1,1,0,32'h100,26'h0,0,1, 32'h504,1,0);
    // stall three cycles at 0x40
    step(1,0,1,32'h0,26'h10,0,1, 32'h40,1,0);
    step(1,0,0,32'h0,26'h0,1,1, 32'h40,0,0);
    step(1,0,0,32'h0,26'h0,1,1, 32'h40,0,0);
    step(1,0,0,32'h0,26'h0,1,1, 32'h40,0,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h40,1,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h44,1,0);
    // branch captured during HOLD, applied on next accept
    step(1,0,0,32'h0,26'h0,1,1, 32'h44,0,0);
    step(1,1,0,32'h10,26'h0,1,1, 32'h44,0,1);
    step(1,0,0,32'h0,26'h0,0,1, 32'h44,1,1);
    step(1,0,0,32'h0,26'h0,0,1, 32'h58,1,0);
    // wrap-around from the top of the address space
    step(1,1,0,32'hFFFF_FFA0,26'h0,0,1, 32'hFFFF_FFFC,1,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h0,1,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h4,1,0);
    // HOLD with a pending redirect, then asynchronous reset mid-cycle
    step(1,0,0,32'h0,26'h0,1,1, 32'h4,0,0);
    step(1,1,0,32'h100,26'h0,1,1, 32'h4,0,1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    push(32'h0, 0, 0);
    -> mon_kick;
    step(0,0,0,32'h0,26'h0,1,1, 32'h0,0,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h0,1,0);
    step(1,0,0,32'h0,26'h0,0,1, 32'h4,1,0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
